seq_shift_add_mult: RTL
=======================

// Module: seq_shift_add_mult
// PURPOSE
// - Iterative radix-2 shift-and-add multiplier producing a full 2*WIDTH-bit product, one partial product per clock.
// - Signed (two's complement) or unsigned operation is selected per transaction.
// - Valid/ready handshake on both input and output; sits between operand-issue logic and result consumers in the multiply datapath.
// PARAMETERS
// - WIDTH   8   operand width in bits; must be >= 2; product width is 2*WIDTH
// PORTS
// - clk_i        in   1        clock; all state updates on the rising edge
// - rst_ni       in   1        asynchronous, active-low reset
// - in_valid_i   in   1        operands and mode valid
// - in_ready_o   out  1        block can accept operands (high only in IDLE)
// - a_i          in   WIDTH    multiplicand
// - b_i          in   WIDTH    multiplier
// - signed_i     in   1        1: a_i/b_i are two's complement; 0: unsigned
// - out_valid_o  out  1        p_o holds the finished product
// - out_ready_i  in   1        consumer accepts p_o
// - p_o          out  2*WIDTH  product, two's complement when signed
// BEHAVIOUR
// - Reset, asynchronous while rst_ni=0:
//   - state=IDLE; in_ready_o=1; out_valid_o=0; p_o=0; all internal registers cleared.
//   - Reset mid-operation abandons the transaction; no result is produced.
// - FSM states: IDLE, CALC, DONE.
// - IDLE:
//   - in_ready_o=1.
//   - Edge with in_valid_i=1: latch mcand=|a|, mplr=|b|, neg=signed_i&(a[MSB]^b[MSB]); acc=0; cnt=0; go to CALC.
//   - Unsigned mode: |x|=x.
//   - Signed mode: |x| is the WIDTH-bit unsigned magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), with no overflow.
// - CALC, one iteration per edge:
//   - {c,sum} = acc[2W-1:W] + (mplr[0] ? mcand : 0), computed as a (WIDTH+1)-bit sum.
//   - acc = {c,sum,acc[W-1:1]}; mplr >>= 1; cnt++.
//   - After exactly WIDTH iterations go to DONE.
//   - On the transition edge, p_o = neg ? (~acc_final+1) : acc_final, truncated to 2*WIDTH bits.
// - DONE:
//   - out_valid_o=1; p_o held stable.
//   - Edge with out_ready_i=1: go to IDLE, out_valid_o=0.
//   - p_o keeps its last value until the next result is written.
// - Latency:
//   - Acceptance edge E0; p_o and out_valid_o are valid after edge E0+WIDTH.
//   - The earliest next acceptance is on the edge after the output handshake.
//   - Throughput is 1 result per WIDTH+2 cycles with out_ready_i tied high.
// - Boundary rules:
//   - in_valid_i while in CALC or DONE: ignored; in_ready_o=0 and operands are not sampled.
//   - No same-cycle accept in DONE; DONE->IDLE and a new acceptance never share an edge.
//   - Operand changes after acceptance have no effect on the transaction in flight.
//   - Zero operands still take the full WIDTH iterations; there is no early termination.
//   - out_ready_i may be high before out_valid_o; the handshake completes on the first DONE edge.
//   - Signed zero result: p_o=0, never negative zero.
// STRUCTURE
// - Package mult_pkg:
//   - state enum {IDLE, CALC, DONE} (2 bits).
//   - Default WIDTH constant.
//   - Counter width function clog2(WIDTH+1).
// - Sub-module ripple_adder #(WIDTH): WIDTH-bit ripple-carry adder built as a chain of fa full-adder cells, with carry-out; used for the CALC partial-sum add.
// - Final negation uses a separate 2*WIDTH-bit increment in the top level.
// TESTING (WIDTH=8)
// - Unsigned, a=0xFF, b=0xFF, signed_i=0 -> p_o=0xFE01, out_valid_o high exactly 8 cycles after the accept edge.
// - Signed, a=0x80 (-128), b=0x80 (-128) -> p_o=0x4000.
// - Signed, a=0x80 (-128), b=0x7F (127) -> p_o=0xC080 (-16256).
// - Signed, a=0xFD (-3), b=0x05 -> p_o=0xFFF1.
// - Signed, a=0x00, b=0x9C -> p_o=0x0000.
// - Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> p_o stable and in_ready_o=0 throughout.
//   - in_valid_i pulsed during CALC is ignored.
//   - Release out_ready_i -> IDLE next edge; the following transaction is accepted one edge later.
// - Reset mid-CALC:
//   - Assert rst_ni=0 at iteration 4 -> immediately out_valid_o=0, p_o=0, in_ready_o=1.
//   - Release rst_ni, issue 3*7 -> p_o=0x0015.
// - Randomized: 10k random a/b/signed_i with random out_ready_i stalls -> every result matches the reference model product.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full-adder cell used to build the ripple-carry partial-sum adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder with carry-out, built as a chain of fa cells.
module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative radix-2 shift-and-add multiplier, one partial product per clock,
// signed or unsigned per transaction, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready_o high
//   CALC  | one add/shift iteration per clock, WIDTH iterations total
//   DONE  | p_o holds the product, out_valid_o high until consumer accepts
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic             neg_q;
  // Bit 0 of the accumulator only ever shifts out, so it is never stored.
  logic [PW-1:1]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    p_q;

  logic             accept;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    p_nxt;

  // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

  assign addend = mplr_q[0] ? mcand_q : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (acc_q[PW-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  assign acc_nxt = {carry, sum, acc_q[WIDTH-1:1]};
  assign p_nxt   = neg_q ? (~acc_nxt + PW'(1)) : acc_nxt;
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else if (accept) begin
      mcand_q <= a_mag;
      mplr_q  <= b_mag;
      neg_q   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (step) begin
      acc_q  <= acc_nxt[PW-1:1];
      mplr_q <= mplr_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
      if (last) begin
        p_q <= p_nxt;
      end
    end
  end

  assign p_o = p_q;

endmodule
